// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// reset defaults and the NOP instruction word.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC_DEFAULT  = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: sequential step with wrap, or aligned branch target.
// With FETCH_MISALIGN_TRAP_EN the target keeps bit 1 and a set bit 1 is flagged.
module pc_next
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] WRAP_PC  = WRAP_PC_DEFAULT
) (
    input  logic [31:0] pc_i,
    input  logic        next_pc_src_i,
    input  logic [31:0] br_target_i,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        br_misalign_o,
`endif
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o
);

    logic [31:0] seq_pc;
    logic [31:0] tgt_pc;

    assign pc_plus4_o = pc_i + 32'd4;

    // Sequential fetch past the top word returns to the reset vector.
    assign seq_pc = (pc_i == WRAP_PC) ? RESET_PC : pc_plus4_o;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic unused_tgt_bit0;
    assign unused_tgt_bit0 = br_target_i[0];
    assign tgt_pc          = {br_target_i[31:1], 1'b0};
    assign br_misalign_o   = br_target_i[1];
`else
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^br_target_i[1:0];
    assign tgt_pc          = {br_target_i[31:2], 2'b00};
`endif

    assign next_pc_o = next_pc_src_i ? tgt_pc : seq_pc;

endmodule : pc_next

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/EXEC sequencer holding PC and the fetched word.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a sticky MisalignTrap output.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] WRAP_PC  = WRAP_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        NextPCSrc,
    input  logic [31:0] BrTarget,
    input  logic        Stall,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        MisalignTrap,
`endif
    output logic        InstrValid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  next_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    logic br_misalign;
`endif

    pc_next #(
        .RESET_PC (RESET_PC),
        .WRAP_PC  (WRAP_PC)
    ) u_pc_next (
        .pc_i          (pc_q),
        .next_pc_src_i (NextPCSrc),
        .br_target_i   (BrTarget),
`ifdef FETCH_MISALIGN_TRAP_EN
        .br_misalign_o (br_misalign),
`endif
        .pc_plus4_o    (PCPlus4),
        .next_pc_o     (next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q  <= trap_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_d  = trap_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                // A trapped core parks here until the next reset.
                if (!trap_q) begin
                    state_d = ST_FETCH;
                end
`else
                state_d = ST_FETCH;
`endif
            end
            ST_FETCH: begin
                // IMemData is only looked at on an acked cycle, so X elsewhere never lands in Instr.
                if (IMemAck) begin
                    instr_d = IMemData;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!Stall) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (NextPCSrc && br_misalign) begin
                        trap_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
`else
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign IMemReq    = (state_q == ST_FETCH);
    assign InstrValid = (state_q == ST_EXEC);
    assign IMemAddr   = pc_q;
    assign PC         = pc_q;
    assign Instr      = instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign MisalignTrap = trap_q;
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each ack pushes the expected {PC, Instr}
// pair, which is popped and compared when the unit reaches EXEC.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        NextPCSrc;
    logic [31:0] BrTarget;
    logic        Stall;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        InstrValid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        MisalignTrap;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] model_pc;
    int          n_checks;
    int          n_fail;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .NextPCSrc    (NextPCSrc),
        .BrTarget     (BrTarget),
        .Stall        (Stall),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemAck      (IMemAck),
        .IMemData     (IMemData),
        .Instr        (Instr),
        .PC           (PC),
        .PCPlus4      (PCPlus4),
`ifdef FETCH_MISALIGN_TRAP_EN
        .MisalignTrap (MisalignTrap),
`endif
        .InstrValid   (InstrValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Acknowledge the current FETCH and record what EXEC must show.
    task automatic ack_now(input logic [31:0] data);
        exp_t x;
        IMemAck  = 1'b1;
        IMemData = data;
        x.pc     = model_pc;
        x.instr  = data;
        sb.push_back(x);
        @(negedge clk);
        IMemAck  = 1'b0;
        IMemData = $urandom;
    endtask

    // Leave EXEC with the given branch decision and advance the model PC.
    task automatic exec_release(input logic src, input logic [31:0] tgt);
        Stall     = 1'b0;
        NextPCSrc = src;
        BrTarget  = tgt;
        @(negedge clk);
        NextPCSrc = 1'b0;
        BrTarget  = $urandom;
        if (src) model_pc = {tgt[31:2], 2'b00};
        else     model_pc = (model_pc == 32'hFFFF_FFFC) ? 32'h0 : model_pc + 32'd4;
    endtask

    task automatic test_reset;
        rst = 1'b1; NextPCSrc = 1'b0; BrTarget = '0; Stall = 1'b0;
        IMemAck = 1'b0; IMemData = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (IMemReq !== 1'b0)   begin n_fail++; $display("FAIL rst_req: got %0b want 0", IMemReq); end
        n_checks++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", InstrValid); end
        n_checks++; if (PC !== 32'h0)        begin n_fail++; $display("FAIL rst_pc: got %h want 00000000", PC); end
        n_checks++; if (Instr !== NOP)       begin n_fail++; $display("FAIL rst_instr: got %h want %h", Instr, NOP); end
        n_checks++; if (PCPlus4 !== 32'h4)   begin n_fail++; $display("FAIL rst_pcplus4: got %h want 00000004", PCPlus4); end
`ifdef FETCH_MISALIGN_TRAP_EN
        n_checks++; if (MisalignTrap !== 1'b0) begin n_fail++; $display("FAIL rst_trap: got %0b want 0", MisalignTrap); end
`endif
        rst = 1'b0;
        #1;
        n_checks++; if (IMemReq !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %0b want 0", IMemReq); end
        @(negedge clk);
        model_pc = 32'h0;
        sb.delete();
    endtask

    task automatic test_basic;
        n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin n_fail++; $display("FAIL basic_req: got req=%0b addr=%h want 1/00000000", IMemReq, IMemAddr); end
        n_checks++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL basic_novalid: got %0b want 0", InstrValid); end
        @(negedge clk);
        ack_now(32'hA000_0001);
        e = sb.pop_front();
        n_checks++; if (InstrValid !== 1'b1 || IMemReq !== 1'b0) begin n_fail++; $display("FAIL basic_exec: got valid=%0b req=%0b want 1/0", InstrValid, IMemReq); end
        n_checks++; if (PC !== e.pc || Instr !== e.instr) begin n_fail++; $display("FAIL basic_sb: got pc=%h instr=%h want %h/%h", PC, Instr, e.pc, e.instr); end
        exec_release(1'b0, 32'h0);
        n_checks++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_1cyc: got %0b want 0", InstrValid); end
        n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h4) begin n_fail++; $display("FAIL basic_next: got req=%0b addr=%h want 1/00000004", IMemReq, IMemAddr); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== model_pc) begin n_fail++; $display("FAIL b2b_req[%0d]: got req=%0b addr=%h want 1/%h", i, IMemReq, IMemAddr, model_pc); end
            ack_now(32'h1000_0000 + i);
            e = sb.pop_front();
            n_checks++; if (InstrValid !== 1'b1 || PC !== e.pc || Instr !== e.instr) begin n_fail++; $display("FAIL b2b_exec[%0d]: got v=%0b pc=%h instr=%h want 1/%h/%h", i, InstrValid, PC, Instr, e.pc, e.instr); end
            exec_release(1'b0, 32'h0);
        end
    endtask

    task automatic test_branch;
        ack_now(32'h0000_0063);
        e = sb.pop_front();
        n_checks++; if (PC !== e.pc || Instr !== e.instr) begin n_fail++; $display("FAIL br_sb: got pc=%h instr=%h want %h/%h", PC, Instr, e.pc, e.instr); end
        exec_release(1'b1, 32'h0000_0101);
        n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0000_0100) begin n_fail++; $display("FAIL br_target: got req=%0b addr=%h want 1/00000100", IMemReq, IMemAddr); end
    endtask

    task automatic test_wait;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== model_pc || InstrValid !== 1'b0) begin n_fail++; $display("FAIL wait[%0d]: got req=%0b addr=%h v=%0b want 1/%h/0", i, IMemReq, IMemAddr, InstrValid, model_pc); end
            IMemData = 'x;
            @(negedge clk);
        end
        ack_now(32'hCAFE_0001);
        e = sb.pop_front();
        n_checks++; if (InstrValid !== 1'b1 || PC !== e.pc || Instr !== e.instr) begin n_fail++; $display("FAIL wait_exec: got v=%0b pc=%h instr=%h want 1/%h/%h", InstrValid, PC, Instr, e.pc, e.instr); end
        exec_release(1'b0, 32'h0);
    endtask

    task automatic test_stall;
        ack_now(32'h5555_AAAA);
        e = sb.pop_front();
        Stall    = 1'b1;
        BrTarget = 32'h0000_0500;
        IMemAck  = 1'b1;
        IMemData = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            NextPCSrc = ~i[0];
            @(negedge clk);
            n_checks++; if (InstrValid !== 1'b1 || IMemReq !== 1'b0 || PC !== e.pc || Instr !== e.instr) begin n_fail++; $display("FAIL stall[%0d]: got v=%0b req=%0b pc=%h instr=%h want 1/0/%h/%h", i, InstrValid, IMemReq, PC, Instr, e.pc, e.instr); end
        end
        IMemAck = 1'b0;
        exec_release(1'b0, 32'h0000_0500);
        n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== model_pc) begin n_fail++; $display("FAIL stall_release: got req=%0b addr=%h want 1/%h", IMemReq, IMemAddr, model_pc); end
    endtask

    task automatic test_wrap;
        ack_now(32'h0000_006F);
        e = sb.pop_front();
        exec_release(1'b1, 32'hFFFF_FFFC);
        n_checks++; if (IMemAddr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got %h want fffffffc", IMemAddr); end
        ack_now(32'h7777_0000);
        e = sb.pop_front();
        n_checks++; if (PC !== e.pc || Instr !== e.instr) begin n_fail++; $display("FAIL wrap_sb: got pc=%h instr=%h want %h/%h", PC, Instr, e.pc, e.instr); end
        n_checks++; if (PCPlus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pcplus4: got %h want 00000000", PCPlus4); end
        exec_release(1'b0, 32'h0);
        n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got req=%0b addr=%h want 1/00000000", IMemReq, IMemAddr); end
    endtask

    task automatic test_reset_mid_fetch;
        ack_now(32'h0000_0013);
        e = sb.pop_front();
        exec_release(1'b1, 32'h0000_0040);
        n_checks++; if (IMemAddr !== 32'h40) begin n_fail++; $display("FAIL midrst_addr: got %h want 00000040", IMemAddr); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (IMemReq !== 1'b0 || PC !== 32'h0 || InstrValid !== 1'b0) begin n_fail++; $display("FAIL midrst_async: got req=%0b pc=%h v=%0b want 0/00000000/0", IMemReq, PC, InstrValid); end
        IMemAck  = 1'b1;
        IMemData = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got req=%0b v=%0b want 0/0", IMemReq, InstrValid); end
        @(negedge clk);
        IMemAck = 1'b0;
        n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0 || InstrValid !== 1'b0 || Instr !== NOP) begin n_fail++; $display("FAIL midrst_lateack: got req=%0b addr=%h v=%0b instr=%h want 1/00000000/0/%h", IMemReq, IMemAddr, InstrValid, Instr, NOP); end
        model_pc = 32'h0;
        sb.delete();
    endtask

    task automatic test_misalign;
        ack_now(32'h0000_0067);
        e = sb.pop_front();
`ifdef FETCH_MISALIGN_TRAP_EN
        Stall     = 1'b0;
        NextPCSrc = 1'b1;
        BrTarget  = 32'h0000_0102;
        @(negedge clk);
        NextPCSrc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (MisalignTrap !== 1'b1 || PC !== e.pc || IMemReq !== 1'b0 || InstrValid !== 1'b0) begin n_fail++; $display("FAIL trap[%0d]: got t=%0b pc=%h req=%0b v=%0b want 1/%h/0/0", i, MisalignTrap, PC, IMemReq, InstrValid, e.pc); end
            IMemAck = ~IMemAck;
            @(negedge clk);
        end
        IMemAck = 1'b0;
`else
        exec_release(1'b1, 32'h0000_0102);
        n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0000_0100) begin n_fail++; $display("FAIL misalign_ignored: got req=%0b addr=%h want 1/00000100", IMemReq, IMemAddr); end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_pc = 32'h0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_branch();
        test_wait();
        test_stall();
        test_wrap();
        test_reset_mid_fetch();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: WRAP_PC, 32'hFFFF_FFFC, highest word address; sequential fetch past it wraps to RESET_PC.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 NextPCSrc  input  1  branch/jump taken, from branch unit; sampled only in EXEC.
REQ-006 BrTarget  input  32  branch/jump target from ALU.
REQ-007 Stall  input  1  holds current instruction in EXEC.
REQ-008 IMemReq  output  1  instruction-memory read request.
REQ-009 IMemAddr  output  32  read address; equals PC.
REQ-010 IMemAck  input  1  read data valid this cycle.
REQ-011 IMemData  input  32  instruction word.
REQ-012 Instr  output  32  registered instruction.
REQ-013 PC  output  32  address of Instr.
REQ-014 PCPlus4  output  32  PC+4, combinational, modulo 2^32.
REQ-015 InstrValid  output  1  Instr/PC valid for execution.
REQ-016 MisalignTrap  output  1  present only with FETCH_MISALIGN_TRAP_EN.

Function
REQ-017 FSM states: IDLE, FETCH, EXEC; encoding from shared package.
REQ-018 IDLE: one cycle after reset release -> FETCH; IMemReq=0, InstrValid=0.
REQ-019 FETCH: IMemReq=1, IMemAddr=PC, held stable until IMemAck=1; ack with no req is ignored.
REQ-020 FETCH with IMemAck=1: Instr<=IMemData, -> EXEC next cycle; ack in the first FETCH cycle is legal (minimum fetch latency 1 cycle).
REQ-021 EXEC: InstrValid=1, IMemReq=0; Stall=1 holds state, PC, Instr.
REQ-022 EXEC with Stall=0: PC<={BrTarget[31:1],1'b0} if NextPCSrc=1, else PC+4 (PC=WRAP_PC -> RESET_PC); -> FETCH.
REQ-023 NextPCSrc and BrTarget ignored outside EXEC or while Stall=1.
REQ-024 Throughput without stall or memory wait: one instruction per 2 cycles.
REQ-025 X on IMemData outside an acked FETCH cycle shall not propagate to Instr.

Reset
REQ-026 rst=1 asynchronously: state=IDLE, PC=RESET_PC, Instr=32'h0000_0013 (NOP), InstrValid=0, IMemReq=0, MisalignTrap=0.
REQ-027 Reset mid-FETCH abandons the request immediately; a late IMemAck after reset release is ignored while in IDLE.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN defined: taken branch with BrTarget[1]=1 sets MisalignTrap=1, PC unchanged, -> IDLE-hold; sticky until rst.
REQ-029 Macro undefined: no MisalignTrap port; BrTarget[1] ignored, target used as {BrTarget[31:2],2'b00}.

Structure
REQ-030 Shared package holds FSM state enum, RESET_PC default, NOP constant.
REQ-031 One sub-module pc_next (combinational next-PC select, wrap and alignment); FSM and registers in fetch_unit.

Verification
REQ-032 Reset release, ack 1 cycle after req -> IMemAddr=0x0, Instr=IMemData, InstrValid high 1 cycle, next IMemAddr=0x4.
REQ-033 EXEC, NextPCSrc=1, BrTarget=0x0000_0101 -> next IMemAddr=0x0000_0100.
REQ-034 Ack delayed 5 cycles -> IMemReq and IMemAddr stable 5 cycles, InstrValid=0 throughout.
REQ-035 Stall=1 for 3 EXEC cycles with NextPCSrc toggling -> PC, Instr frozen; branch taken only per value at Stall release.
REQ-036 PC=0xFFFF_FFFC, NextPCSrc=0 -> next IMemAddr=RESET_PC.
REQ-037 rst pulsed mid-FETCH (PC=0x40) -> IMemReq=0 same cycle, PC=RESET_PC; with macro, BrTarget=0x102 taken -> MisalignTrap=1, PC held.
